// File: rtl/soc_system_input_pio_debounced.sv
// soc_system_input_pio_debounced: Avalon-MM PIO with per-channel sync, debounce, edge capture and masked irq
module soc_system_input_pio_debounced #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] s, db_q, db_d, upd, ec_q, ec_d, mask_q, rise_en_q, fall_en_q, w1c, wd;
  logic [31:0]      rd_q, rd_d;
  logic             irq_q, wr, unused_wd;
  assign s         = sync_q[SYNC_STAGES-1];
  assign wr        = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign readdata  = rd_q;
  assign irq       = irq_q;
  always_comb begin
    upd   = '0;
    cnt_d = '{default: '0};
    for (int i = 0; i < WIDTH; i++) begin
      upd[i]   = s[i] != db_q[i] && cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1);
      cnt_d[i] = (s[i] == db_q[i] || upd[i]) ? '0 : cnt_q[i] + CNT_W'(1);
    end
    // upd only fires where s and db disagree, so xor moves db onto s
    db_d = db_q ^ upd;
    w1c  = (wr && address == 3'd3) ? wd : '0;
    ec_d = (ec_q & ~w1c) | (upd & s & rise_en_q) | (upd & ~s & fall_en_q);
    rd_d = '0;
    case (address)
      3'd0:    rd_d = 32'(db_q);
      3'd1:    rd_d = 32'(mask_q);
      3'd2:    rd_d = 32'(rise_en_q);
      3'd3:    rd_d = 32'(ec_q);
      3'd4:    rd_d = 32'(fall_en_q);
      3'd5:    rd_d = 32'(s);
      default: rd_d = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '{default: '0};
      cnt_q     <= '{default: '0};
      db_q      <= '0;
      ec_q      <= '0;
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '1;
      rd_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      cnt_q <= cnt_d;
      db_q  <= db_d;
      ec_q  <= ec_d;
      if (wr && address == 3'd1) mask_q <= wd;
      if (wr && address == 3'd2) rise_en_q <= wd;
      if (wr && address == 3'd4) fall_en_q <= wd;
      rd_q  <= rd_d;
      irq_q <= |(ec_q & mask_q);
    end
  end
endmodule

// File: tb/tb_soc_system_input_pio_debounced.sv
// tb_soc_system_input_pio_debounced: scoreboard bench for the debounced input PIO
module tb_soc_system_input_pio_debounced;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  in_port = '0;
  logic        irq;
  logic [31:0] sb [$];
  logic [31:0] e;
  int          checks = 0;
  int          errors = 0;

  soc_system_input_pio_debounced #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_out readdata=%h irq=%b want 0/0", readdata, irq);
    end
    reset = 1'b0;
    for (int a = 0; a < 6; a++) begin
      address = 3'(a);
      sb.push_back(a == 4 ? 32'hF : 32'h0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (readdata !== e) begin errors++; $display("FAIL reset_reg%0d got %h want %h", a, readdata, e); end
    end
  endtask

  task automatic test_latency();
    address = 3'd0;
    @(negedge clk);
    in_port = 4'h1;
    for (int k = 1; k <= 8; k++) sb.push_back(k >= 7 ? 32'h1 : 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (readdata !== e) begin errors++; $display("FAIL latency_edge%0d got %h want %h", k, readdata, e); end
    end
    address = 3'd3;
    sb.push_back(32'h0);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (readdata !== e) begin errors++; $display("FAIL latency_norise got %h want %h", readdata, e); end
  endtask

  task automatic test_glitch();
    in_port = 4'h3;
    repeat (10) @(negedge clk);
    address = 3'd0;
    in_port = 4'h1;
    repeat (3) @(negedge clk);
    in_port = 4'h3;
    for (int k = 0; k < 10; k++) sb.push_back(32'h3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (readdata !== e) begin errors++; $display("FAIL glitch_db%0d got %h want %h", k, readdata, e); end
    end
    address = 3'd3;
    sb.push_back(32'h0);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (readdata !== e) begin errors++; $display("FAIL glitch_ec got %h want %h", readdata, e); end
    in_port = 4'h1;
    repeat (10) @(negedge clk);
    address = 3'd0;
    sb.push_back(32'h1);
    sb.push_back(32'h2);
    @(negedge clk);
    address = 3'd3;
    e = sb.pop_front();
    checks++;
    if (readdata !== e) begin errors++; $display("FAIL fall_db got %h want %h", readdata, e); end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (readdata !== e) begin errors++; $display("FAIL fall_ec got %h want %h", readdata, e); end
  endtask

  task automatic test_irq();
    wr(3'd1, 32'h2);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
    wr(3'd3, 32'h2);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    address = 3'd3;
    sb.push_back(32'h0);
    @(negedge clk);
    address = 3'd1;
    e = sb.pop_front();
    checks++;
    if (readdata !== e) begin errors++; $display("FAIL w1c_ec got %h want %h", readdata, e); end
    sb.push_back(32'h2);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (readdata !== e) begin errors++; $display("FAIL mask_rd got %h want %h", readdata, e); end
  endtask

  task automatic test_rise();
    wr(3'd2, 32'hF);
    wr(3'd4, 32'h0);
    in_port = 4'h5;
    repeat (10) @(negedge clk);
    address = 3'd3;
    sb.push_back(32'h4);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (readdata !== e) begin errors++; $display("FAIL rise_ec got %h want %h", readdata, e); end
    in_port = 4'h1;
    repeat (10) @(negedge clk);
    sb.push_back(32'h4);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (readdata !== e) begin errors++; $display("FAIL nofall_ec got %h want %h", readdata, e); end
    wr(3'd3, 32'h4);
    sb.push_back(32'h0);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (readdata !== e) begin errors++; $display("FAIL w1c2_ec got %h want %h", readdata, e); end
    in_port = 4'h5;
    repeat (5) @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = 32'h4;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    sb.push_back(32'h4);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (readdata !== e) begin errors++; $display("FAIL setwins_ec got %h want %h", readdata, e); end
  endtask

  task automatic test_reset_mid();
    in_port = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    address = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL midreset_out readdata=%h irq=%b want 0/0", readdata, irq);
    end
    for (int k = 1; k <= 8; k++) sb.push_back(k >= 7 ? 32'hF : 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (readdata !== e) begin errors++; $display("FAIL midreset_db%0d got %h want %h", k, readdata, e); end
    end
    for (int a = 1; a < 8; a++) begin
      address = 3'(a);
      sb.push_back(a == 4 ? 32'hF : a == 5 ? 32'hF : 32'h0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (readdata !== e) begin errors++; $display("FAIL midreset_reg%0d got %h want %h", a, readdata, e); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_irq();
    test_rise();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
